// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS.hh elapsed-time counter in BCD, driven by a one-cycle
// tick enable and single-cycle start/stop, clear and lap button pulses.
// Optional lap/freeze display is built only when STOPWATCH_LAP_EN is defined;
// without it the lap input is ignored and lap_active is tied low.
module stopwatch_bcd #(
  parameter int unsigned TICKS_PER_HUND = 1,  // ticks per 0.01 s step, 1..65535
  parameter int unsigned ROLLOVER       = 0   // 1: wrap at 59:59.99, 0: saturate
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] bcd,
  output logic        running,
  output logic        ovf,
  output logic        wrap,
  output logic        lap_active
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_HUND - 1);

  logic [1:0]  state_reg, state_next;
  logic [15:0] presc_reg, presc_next;
  logic [23:0] count_reg, count_next;
  logic [23:0] count_inc;
  logic        ovf_reg, ovf_next;
  logic        wrap_reg, wrap_next;
  logic [6:0]  carry;
  logic        at_max;

  // BCD increment: digit order from LSB is hund_ones, hund_tens, sec_ones,
  // sec_tens, min_ones, min_tens; the tens of seconds and minutes stop at 5.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      localparam logic [3:0] LIM = (gi == 3 || gi == 5) ? 4'd5 : 4'd9;
      logic [3:0] digit;
      logic       at_lim;
      assign digit  = count_reg[gi*4 +: 4];
      assign at_lim = (digit == LIM);
      assign carry[gi+1] = carry[gi] & at_lim;
      assign count_inc[gi*4 +: 4] = carry[gi] ? (at_lim ? 4'd0 : digit + 4'd1) : digit;
    end
  endgenerate

  // Carry out of the top digit means every digit sits at its limit: 59:59.99.
  assign at_max = carry[6];

  // Next-state logic for the run/pause FSM, prescaler and live count.
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    wrap_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
      presc_next = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_stop) state_next = RUN;
        end
        RUN: begin
          // The tick is accounted first, then start_stop may pause.
          if (tick) begin
            if (presc_reg == PRESC_LAST) begin
              presc_next = '0;
              if (!at_max) begin
                count_next = count_inc;
              end else if (ROLLOVER != 0) begin
                count_next = '0;
                wrap_next  = 1'b1;
              end else begin
                ovf_next   = 1'b1;
                state_next = DONE;
              end
            end else begin
              presc_next = presc_reg + 16'd1;
            end
          end
          // Saturation to DONE takes precedence over a simultaneous pause.
          if (start_stop && state_next == RUN) state_next = PAUSED;
        end
        PAUSED: begin
          // Prescaler is held, not cleared, so partial hundredths survive.
          if (start_stop) state_next = RUN;
        end
        default: begin
          // DONE: only clear leaves this state.
        end
      endcase
    end
  end

  // State, prescaler, count and status flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign running = (state_reg == RUN);
  assign ovf     = ovf_reg;
  assign wrap    = wrap_reg;

`ifdef STOPWATCH_LAP_EN
  logic        lap_active_reg, lap_active_next;
  logic [23:0] hold_reg, hold_next;

  // Lap toggles a frozen snapshot; the snapshot takes the pre-increment count.
  always_comb begin
    lap_active_next = lap_active_reg;
    hold_next       = hold_reg;
    if (clear) begin
      lap_active_next = 1'b0;
    end else if (lap) begin
      if (lap_active_reg) begin
        lap_active_next = 1'b0;
      end else if (state_reg == RUN || state_reg == PAUSED) begin
        hold_next       = count_reg;
        lap_active_next = 1'b1;
      end
    end
  end

  // Lap hold register and frozen-display flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_active_reg <= 1'b0;
      hold_reg       <= '0;
    end else begin
      lap_active_reg <= lap_active_next;
      hold_reg       <= hold_next;
    end
  end

  assign bcd        = lap_active_reg ? hold_reg : count_reg;
  assign lap_active = lap_active_reg;
`else
  // Lap feature not built: the input is accepted but has no effect.
  logic lap_unused;
  assign lap_unused = lap;
  assign bcd        = count_reg;
  assign lap_active = 1'b0;
`endif

endmodule
